// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the pipeline register chain: the depth
//            ceiling, the occupancy popcount helper and the packed per-stage
//            processor control bits that callers fold into the stage payload.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 16;
  // Wide enough for PIPE_MAX_DEPTH stages plus one skid entry.
  localparam int PIPE_CNT_W     = 5;

  // Processor control bits carried alongside the instruction; callers pack
  // this struct into the low bits of the WIDTH payload.
  typedef struct packed {
    logic branch;
    logic jump;
    logic mem_wr;
    logic mem_to_reg;
    logic mov;
    logic is_byte;
    logic is_half;
    logic sext;
    logic jal;
    logic use_reg;
  } pipe_ctrl_t;

  function automatic logic [PIPE_CNT_W-1:0] pipe_popcnt(
    input logic [PIPE_MAX_DEPTH-1:0] bits
  );
    logic [PIPE_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < PIPE_MAX_DEPTH; i++) begin
      cnt = cnt + {{(PIPE_CNT_W-1){1'b0}}, bits[i]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Purpose  : One-entry valid/ready skid buffer placed ahead of stage 0.
//            in_ready is a pure flop output, cutting the combinational
//            ready path from the chain back to the upstream producer.
// Ports    : clock, reset (async, active-low)
//            in_valid/in_ready/in_data    upstream side
//            out_valid/out_ready/out_data toward stage 0
//            flush                        discards a held entry this cycle
//            held                         skid currently holds an entry
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             held
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A held entry always has priority (oldest first); while it is held the
  // upstream sees in_ready=0, so the bypass path is only used when empty.
  assign out_valid = r_valid ? ~flush : in_valid;
  assign out_data  = r_valid ? r_data : in_data;
  assign in_ready  = ~r_valid;
  assign held      = r_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      // Whatever is offered downstream but not taken stays here.
      r_valid <= out_valid & ~out_ready;
      if (!r_valid && in_valid && !out_ready) begin
        r_data <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Purpose  : In-order chain of DEPTH pipeline registers with a per-stage
//            valid/ready handshake. Empty slots collapse (a stalled stage
//            never holds back an empty stage behind it) and a per-stage kill
//            mask squashes younger entries in one cycle.
// Macro    : PIPE_SKID_EN - adds a one-entry skid ahead of stage 0 so that
//            in_ready comes straight from a flop.
// Ports    : clock, reset (async, active-low)
//            in_valid/in_ready/in_data      producer side, enters stage 0
//            kill[DEPTH]                    discards the entry held in stage i
//            out_valid/out_ready/out_data   consumer side, stage DEPTH-1
//            occupancy                      live entries from flops (pre-kill)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [DEPTH-1:0]             kill,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy
);
  import pipe_pkg::*;

  localparam int OCC_W = $clog2(DEPTH+2);

  logic [DEPTH-1:0]      w_valid;
  logic [DEPTH-1:0]      w_ev;
  logic [DEPTH:0]        w_rdy;
  logic [WIDTH-1:0]      w_data [DEPTH];
  logic                  w_s0_valid;
  logic [WIDTH-1:0]      w_s0_data;
  logic                  w_skid_held;
  logic [PIPE_CNT_W-1:0] w_cnt;

  assign w_ev = w_valid & ~kill;

  // A stage can take a new entry if it is (effectively) empty or its own
  // entry is leaving this cycle; a killed stage counts as empty.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_rdy[i] = ~w_ev[i] | w_rdy[i+1];
    end
  end

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (kill[0]),
    .out_valid(w_s0_valid),
    .out_ready(w_rdy[0]),
    .out_data (w_s0_data),
    .held     (w_skid_held)
  );
`else
  assign w_s0_valid  = in_valid;
  assign w_s0_data   = in_data;
  assign in_ready    = w_rdy[0];
  assign w_skid_held = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_xfer;
    logic [WIDTH-1:0] w_src;

    if (i == 0) begin : g_head
      assign w_xfer = w_s0_valid & w_rdy[0];
      assign w_src  = w_s0_data;
    end else begin : g_body
      assign w_xfer = w_ev[i-1] & w_rdy[i];
      assign w_src  = w_data[i-1];
    end

    // Data is not cleared on kill; the valid bit alone retires the entry.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= w_xfer | (w_ev[i] & ~w_rdy[i+1]);
        if (w_xfer) begin
          r_data <= w_src;
        end
      end
    end

    assign w_valid[i] = r_valid;
    assign w_data[i]  = r_data;
  end

  assign out_valid = w_ev[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];

  assign w_cnt     = pipe_popcnt(PIPE_MAX_DEPTH'(w_valid))
                   + {{(PIPE_CNT_W-1){1'b0}}, w_skid_held};
  assign occupancy = OCC_W'(w_cnt);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Purpose  : Self-checking bench for pipe_stage_chain (WIDTH=32, DEPTH=4):
//            a fill/drain vector table plus hand-written backpressure,
//            bubble-collapse, kill and async-reset sequences, with an
//            in-order scoreboard on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

  localparam int c_width = 32;
  localparam int c_depth = 4;
  localparam int c_occ_w = $clog2(c_depth+2);
`ifdef PIPE_SKID_EN
  localparam int c_skid  = 1;
`else
  localparam int c_skid  = 0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [c_width-1:0] in_data;
  logic [c_depth-1:0] kill;
  logic               out_valid;
  logic               out_ready;
  logic [c_width-1:0] out_data;
  logic [c_occ_w-1:0] occupancy;

  pipe_stage_chain #(
    .WIDTH(c_width),
    .DEPTH(c_depth)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .kill     (kill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ev;
    logic [31:0] ed;
    logic [31:0] eo;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic iv, input logic [31:0] id,
                              input logic ev, input logic [31:0] ed,
                              input logic [31:0] eo);
    vec_t v;
    v.iv = iv; v.id = id; v.ev = ev; v.ed = ed; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: record the input handshake, check the output
  // handshake against the oldest expected entry, then step past the edge.
  task automatic sb_edge();
    logic [31:0] exp;
    if (in_valid && in_ready) sb_q.push_back(in_data);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", out_data, 32'hxxxx_xxxx);
      end else begin
        exp = sb_q.pop_front();
        check("sb_out", out_data, exp);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    @(negedge clock);
    sb_edge();
  endtask

  task automatic drain(input int max);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    kill      = '0;
    n = 0;
    while (sb_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    check("drain_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    kill      = '0;
    out_ready = 1'b0;

    tbl[0]  = mk(1, 32'h1, 0, 32'h0, 0);
    tbl[1]  = mk(1, 32'h2, 0, 32'h0, 1);
    tbl[2]  = mk(1, 32'h3, 0, 32'h0, 2);
    tbl[3]  = mk(1, 32'h4, 0, 32'h0, 3);
    tbl[4]  = mk(1, 32'h5, 1, 32'h1, 4);
    tbl[5]  = mk(1, 32'h6, 1, 32'h2, 4);
    tbl[6]  = mk(1, 32'h7, 1, 32'h3, 4);
    tbl[7]  = mk(1, 32'h8, 1, 32'h4, 4);
    tbl[8]  = mk(0, 32'h0, 1, 32'h5, 4);
    tbl[9]  = mk(0, 32'h0, 1, 32'h6, 3);
    tbl[10] = mk(0, 32'h0, 1, 32'h7, 2);
    tbl[11] = mk(0, 32'h0, 1, 32'h8, 1);
    tbl[12] = mk(0, 32'h0, 0, 32'h0, 0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    reset = 1'b1;
    cycle();
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    sb_edge();

    // ---------------- fill / drain table ----------------
    out_ready = 1'b1;
    for (int r = 0; r < 13; r++) begin
      in_valid = tbl[r].iv;
      in_data  = tbl[r].id;
      @(negedge clock);
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[r].ev));
      if (tbl[r].ev) check("tbl_out_data", out_data, tbl[r].ed);
      check("tbl_in_ready",  32'(in_ready),  32'd1);
      check("tbl_occupancy", 32'(occupancy), tbl[r].eo);
      sb_edge();
    end
    drain(5);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = (c_skid == 0);
      in_data  = 32'hEE;
      @(negedge clock);
      check("bp_in_ready",  32'(in_ready),  32'(c_skid));
      check("bp_occupancy", 32'(occupancy), 32'd4);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  out_data,       32'hA0);
      sb_edge();
    end
    drain(20);

    // ---------------- bubble collapse ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    in_valid = 1'b1;
    in_data  = 32'h66;
    cycle();
    in_data = 32'h77;
    @(negedge clock);
    check("bub_in_ready",  32'(in_ready),  32'd1);
    check("bub_occupancy", 32'(occupancy), 32'd2);
    sb_edge();
    in_valid = 1'b0;
    @(negedge clock);
    check("bub_occ_after", 32'(occupancy), 32'd3);
    check("bub_out_data",  out_data,       32'h55);
    sb_edge();
    drain(20);

    // ---------------- kill of stages 0 and 1 ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      in_data = 32'h10 + 32'(k);
      cycle();
    end
    in_valid  = 1'b0;
    kill      = 4'b0011;
    out_ready = 1'b1;
    @(negedge clock);
    check("kill_out_data",  out_data,       32'h13);
    check("kill_occupancy", 32'(occupancy), 32'd4);
    sb_q.delete(3);
    sb_q.delete(2);
    sb_edge();
    kill = '0;
    @(negedge clock);
    check("kill_occ_after", 32'(occupancy), 32'd1);
    check("kill_out_next",  out_data,       32'h12);
    sb_edge();
    @(negedge clock);
    check("kill_out_valid_end", 32'(out_valid), 32'd0);
    check("kill_occ_end",       32'(occupancy), 32'd0);
    sb_edge();

    // ---------------- kill + accept at stage 0 ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h20;
    cycle();
    kill    = 4'b0001;
    in_data = 32'h21;
    @(negedge clock);
    check("ka_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete(0);
    sb_edge();
    kill     = '0;
    in_valid = 1'b0;
    @(negedge clock);
    check("ka_occupancy", 32'(occupancy), 32'd1);
    sb_edge();
    drain(10);

    // ---------------- kill of the output stage ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h30;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    kill      = 4'b1000;
    out_ready = 1'b1;
    @(negedge clock);
    check("k3_out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    sb_edge();
    kill = '0;
    @(negedge clock);
    check("k3_occupancy", 32'(occupancy), 32'd0);
    sb_edge();

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4 + c_skid; k++) begin
      in_data = 32'hB0 + 32'(k);
      cycle();
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("ar_occ_before", 32'(occupancy), 32'(c_depth + c_skid));
    #2;
    reset = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_occupancy", 32'(occupancy), 32'd0);
    check("ar_out_data",  out_data,       32'd0);
    sb_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    sb_edge();
    in_valid  = 1'b1;
    in_data   = 32'hC0;
    out_ready = 1'b1;
    cycle();
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
